// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the async FIFO's write port between NREQ requesters,
// granting bursts of up to MAXBURST beats with flow control from wfull/afull.
module fifo_wr_arb #(
   parameter int unsigned DSIZE    = 8,
   parameter int unsigned NREQ     = 4,
   parameter int unsigned MAXBURST = 4
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*DSIZE-1:0] req_data,
   input  logic                  wfull,
   input  logic                  afull,
   output logic [NREQ-1:0]       ack,
   output logic [NREQ-1:0]       gnt,
   output logic                  winc,
   output logic [DSIZE-1:0]      wdata,
   output logic                  busy
);

   localparam int unsigned OW = $clog2(NREQ);
   localparam int unsigned BW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
   localparam logic [OW-1:0] LastInit = OW'(NREQ - 1);
   localparam logic [BW-1:0] BeatMax  = BW'(MAXBURST - 1);

   typedef enum logic {StIdle, StGrant} state_e;

   state_e           state_q, state_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [OW-1:0]    rr_last_q, rr_last_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic             end_b;

   // Nearest requester after 'last' wins; scanning far-to-near lets the last hit stand.
   function automatic logic [OW-1:0] pick(input logic [NREQ-1:0] r, input logic [OW-1:0] last);
      logic [OW-1:0] sel;
      logic [OW-1:0] cand;
      sel = last;
      for (int k = int'(NREQ); k > 0; k--) begin
         cand = OW'((int'(last) + k) % int'(NREQ));
         if (r[cand]) sel = cand;
      end
      return sel;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] o);
      logic [NREQ-1:0] v;
      v    = '0;
      v[o] = 1'b1;
      return v;
   endfunction

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state_q   <= StIdle;
         owner_q   <= '0;
         rr_last_q <= LastInit;
         beat_q    <= '0;
         gnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_last_q <= rr_last_d;
         beat_q    <= beat_d;
         gnt_q     <= gnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_last_d = rr_last_q;
      beat_d    = beat_q;
      gnt_d     = gnt_q;
      winc      = 1'b0;
      ack       = '0;
      wdata     = '0;
      end_b     = 1'b0;
      case (state_q)
         StIdle: begin
            if (|req && !wfull) begin
               owner_d = pick(req, rr_last_q);
               gnt_d   = onehot(owner_d);
               beat_d  = '0;
               state_d = StGrant;
            end
         end
         StGrant: begin
            winc  = req[owner_q] & ~wfull;
            ack   = winc ? onehot(owner_q) : '0;
            wdata = req_data[owner_q*DSIZE +: DSIZE];
            // A withdrawn request ends the burst even while the FIFO is full.
            end_b = (winc && (beat_q == BeatMax || afull)) || !req[owner_q];
            if (end_b) begin
               rr_last_d = owner_q;
               beat_d    = '0;
               if (|req && !wfull) begin
                  owner_d = pick(req, owner_q);
                  gnt_d   = onehot(owner_d);
               end else begin
                  gnt_d   = '0;
                  state_d = StIdle;
               end
            end else if (winc) begin
               beat_d = beat_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign gnt  = gnt_q;
   assign busy = (state_q == StGrant);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: fixed vector table, directed corner sequences and a
// randomized run checked against a cycle-level reference model of the arbiter rules.
module tb_fifo_wr_arb;

   localparam int NREQ     = 4;
   localparam int DSIZE    = 8;
   localparam int MAXBURST = 4;

   logic                  wclk = 1'b0;
   logic                  wrst = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*DSIZE-1:0] req_data = '0;
   logic                  wfull = 1'b0;
   logic                  afull = 1'b0;
   logic [NREQ-1:0]       ack;
   logic [NREQ-1:0]       gnt;
   logic                  winc;
   logic [DSIZE-1:0]      wdata;
   logic                  busy;

   fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
      .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .wfull(wfull),
      .afull(afull), .ack(ack), .gnt(gnt), .winc(winc), .wdata(wdata), .busy(busy)
   );

   always #5 wclk = ~wclk;

   int n_err = 0;
   int n_checks = 0;
   int cyc = 0;

   // Reference model: who owns the port, beats already written, last burst owner.
   bit m_grant;
   int m_owner;
   int m_beats;
   int m_last;

   logic [NREQ-1:0]  last_ack;
   logic [DSIZE-1:0] writes[$];
   int               write_cyc[$];

   typedef struct {
      logic [NREQ-1:0]  req;
      logic             wfull;
      logic             afull;
      logic [NREQ-1:0]  gnt;
      logic [NREQ-1:0]  ack;
      logic             winc;
      logic [DSIZE-1:0] wdata;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   function automatic bit bit_of(input logic [NREQ-1:0] v, input int k);
      logic [NREQ-1:0] t;
      t = v >> k;
      return t[0];
   endfunction

   function automatic logic [DSIZE-1:0] data_of(input int i);
      logic [NREQ*DSIZE-1:0] t;
      t = req_data >> (i * DSIZE);
      return t[DSIZE-1:0];
   endfunction

   function automatic logic [NREQ-1:0] oh(input int i);
      return NREQ'(1) << i;
   endfunction

   task automatic set_data(input int i, input logic [DSIZE-1:0] v);
      logic [NREQ*DSIZE-1:0] m;
      m = '0;
      m[DSIZE-1:0] = '1;
      req_data = (req_data & ~(m << (i * DSIZE))) | ((NREQ*DSIZE)'(v) << (i * DSIZE));
   endtask

   task automatic set_req(input int i, input bit v);
      if (v) req = req | oh(i);
      else   req = req & ~oh(i);
   endtask

   // Round-robin: first requester after 'from', wrapping, 'from' itself last.
   function automatic int rr_next(input int from, input logic [NREQ-1:0] r);
      for (int d = 1; d <= NREQ; d++)
         if (bit_of(r, (from + d) % NREQ)) return (from + d) % NREQ;
      return from;
   endfunction

   function automatic bit model_winc();
      return m_grant && bit_of(req, m_owner) && !wfull;
   endfunction

   task automatic model_reset();
      m_grant = 1'b0;
      m_owner = 0;
      m_beats = 0;
      m_last  = NREQ - 1;
   endtask

   task automatic compare_model();
      bit e_winc;
      e_winc = model_winc();
      check("winc", 32'(winc), 32'(e_winc));
      check("ack", 32'(ack), e_winc ? 32'(oh(m_owner)) : 32'd0);
      check("gnt", 32'(gnt), m_grant ? 32'(oh(m_owner)) : 32'd0);
      check("wdata", 32'(wdata), m_grant ? 32'(data_of(m_owner)) : 32'd0);
      check("busy", 32'(busy), 32'(m_grant));
   endtask

   task automatic model_update();
      bit wrote;
      bit done;
      wrote = model_winc();
      if (!m_grant) begin
         if (req != '0 && !wfull) begin
            m_owner = rr_next(m_last, req);
            m_beats = 0;
            m_grant = 1'b1;
         end
      end else begin
         done = (wrote && (m_beats + 1 == MAXBURST || afull)) || !bit_of(req, m_owner);
         if (done) begin
            m_last = m_owner;
            if (req != '0 && !wfull) begin
               m_owner = rr_next(m_owner, req);
               m_beats = 0;
            end else begin
               m_grant = 1'b0;
            end
         end else if (wrote) begin
            m_beats++;
         end
      end
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic advance();
      last_ack = ack;
      if (winc) begin
         writes.push_back(wdata);
         write_cyc.push_back(cyc);
      end
      @(posedge wclk);
      model_update();
      @(negedge wclk);
      cyc++;
   endtask

   task automatic step();
      settle();
      compare_model();
      advance();
   endtask

   task automatic do_reset();
      @(negedge wclk);
      wrst     = 1'b1;
      req      = '0;
      req_data = '0;
      wfull    = 1'b0;
      afull    = 1'b0;
      model_reset();
      #2;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge wclk);
      wrst     = 1'b0;
      last_ack = '0;
      writes.delete();
      write_cyc.delete();
   endtask

   initial begin
      int cnt;
      int cnts[NREQ];
      int stall_left;
      bit stall_started;

      model_reset();
      last_ack = '0;

      // ---- table: afull rotation, wfull hold, withdrawal to idle, fresh grant
      tbl[0]  = '{4'b1011, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};
      tbl[1]  = '{4'b1011, 1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'hA0};
      tbl[2]  = '{4'b1011, 1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 8'hA1};
      tbl[3]  = '{4'b1011, 1'b0, 1'b1, 4'b1000, 4'b1000, 1'b1, 8'hA3};
      tbl[4]  = '{4'b1011, 1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'hA0};
      tbl[5]  = '{4'b1011, 1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 8'hA1};
      tbl[6]  = '{4'b1011, 1'b0, 1'b1, 4'b1000, 4'b1000, 1'b1, 8'hA3};
      tbl[7]  = '{4'b1011, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'hA0};
      tbl[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'hA0};
      tbl[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
      tbl[10] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
      tbl[11] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hA2};

      do_reset();
      for (int i = 0; i < NREQ; i++) set_data(i, 8'hA0 + 8'(i));
      for (int v = 0; v < 12; v++) begin
         req   = tbl[v].req;
         wfull = tbl[v].wfull;
         afull = tbl[v].afull;
         settle();
         check($sformatf("tbl%0d_gnt", v), 32'(gnt), 32'(tbl[v].gnt));
         check($sformatf("tbl%0d_ack", v), 32'(ack), 32'(tbl[v].ack));
         check($sformatf("tbl%0d_winc", v), 32'(winc), 32'(tbl[v].winc));
         check($sformatf("tbl%0d_wdata", v), 32'(wdata), 32'(tbl[v].wdata));
         advance();
      end

      // ---- single requester, 6 words across two back-to-back bursts
      do_reset();
      set_req(2, 1'b1);
      set_data(2, 8'h10);
      cnt = 0;
      for (int c = 0; c < 14; c++) begin
         step();
         if (last_ack[2]) begin
            cnt++;
            if (cnt == 6) set_req(2, 1'b0);
            else set_data(2, 8'h10 + 8'(cnt));
         end
      end
      check("single_nwrites", 32'(writes.size()), 32'd6);
      if (writes.size() == 6) begin
         for (int k = 0; k < 6; k++) check("single_data", 32'(writes[k]), 32'h10 + 32'(k));
         check("single_no_gap", 32'(write_cyc[5] - write_cyc[0]), 32'd5);
         check("single_first", 32'(write_cyc[0]), 32'(write_cyc[0] > 0 ? write_cyc[0] : -1));
      end

      // ---- round-robin, all four requesters each offering 8 words
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         set_req(i, 1'b1);
         set_data(i, 8'(i << 4));
         cnts[i] = 0;
      end
      for (int c = 0; c < 40; c++) begin
         step();
         for (int i = 0; i < NREQ; i++) begin
            if (last_ack[i]) begin
               cnts[i]++;
               if (cnts[i] == 8) set_req(i, 1'b0);
               else set_data(i, 8'((i << 4) | cnts[i]));
            end
         end
      end
      check("rr_nwrites", 32'(writes.size()), 32'd32);
      if (writes.size() == 32) begin
         for (int k = 0; k < 32; k++)
            check("rr_order", 32'(writes[k]), 32'((((k / 4) % 4) << 4) | ((k / 16) * 4 + k % 4)));
         check("rr_no_gap", 32'(write_cyc[31] - write_cyc[0]), 32'd31);
      end

      // ---- full stall after 2 beats of requester 1
      do_reset();
      set_req(1, 1'b1);
      set_data(1, 8'h20);
      cnt = 0;
      stall_left = 0;
      stall_started = 1'b0;
      for (int c = 0; c < 16; c++) begin
         step();
         if (last_ack[1]) begin
            cnt++;
            if (cnt == 4) set_req(1, 1'b0);
            else set_data(1, 8'h20 + 8'(cnt));
         end
         if (cnt == 2 && !stall_started) begin
            stall_started = 1'b1;
            stall_left = 5;
            wfull = 1'b1;
         end else if (stall_left > 0) begin
            check("stall_gnt", 32'(gnt), 32'b0010);
            stall_left--;
            if (stall_left == 0) wfull = 1'b0;
         end
      end
      check("stall_nwrites", 32'(writes.size()), 32'd4);
      if (writes.size() == 4) begin
         check("stall_last", 32'(writes[3]), 32'h23);
         check("stall_span", 32'(write_cyc[3] - write_cyc[0]), 32'd8);
      end

      // ---- withdrawal: requester 3 drops after one ack, requester 0 waiting
      do_reset();
      set_req(3, 1'b1);
      set_data(3, 8'h30);
      set_data(0, 8'h40);
      step();
      set_req(0, 1'b1);
      step();
      set_req(3, 1'b0);
      settle();
      check("wd_winc", 32'(winc), 32'd0);
      check("wd_ack", 32'(ack), 32'd0);
      compare_model();
      advance();
      settle();
      check("wd_gnt", 32'(gnt), 32'b0001);
      compare_model();
      advance();

      // ---- reset in beat 2 of a burst by requester 2
      do_reset();
      set_req(2, 1'b1);
      set_data(2, 8'h55);
      step();
      step();
      settle();
      compare_model();
      #2;
      wrst = 1'b1;
      #1;
      check("mrst_winc", 32'(winc), 32'd0);
      check("mrst_ack", 32'(ack), 32'd0);
      check("mrst_gnt", 32'(gnt), 32'd0);
      model_reset();
      @(negedge wclk);
      wrst = 1'b0;
      req  = 4'b0101;
      set_data(0, 8'h66);
      step();
      settle();
      check("mrst_first", 32'(gnt), 32'b0001);
      compare_model();
      advance();

      // ---- randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         wfull = ($urandom % 8) == 0;
         afull = ($urandom % 6) == 0;
         for (int i = 0; i < NREQ; i++) begin
            if (bit_of(req, i) && last_ack[i]) begin
               if ($urandom % 3 == 0) set_req(i, 1'b0);
               else set_data(i, 8'($urandom));
            end else if (!bit_of(req, i)) begin
               if ($urandom % 2 == 0) begin
                  set_req(i, 1'b1);
                  set_data(i, 8'($urandom));
               end
            end else if ($urandom % 50 == 0) begin
               set_req(i, 1'b0);
            end
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
